alu_word_sequencer: RTL



---
 rtl/alu_word_sequencer_pkg.sv | 18 +
 rtl/alu_word_sequencer_if.sv | 51 +++++
 rtl/alu_word_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_word_sequencer_pkg.sv
// rtl/alu_word_sequencer_pkg.sv - shared types and constants for the ALU word sequencer
package alu_word_sequencer_pkg;

   localparam int SLICE_W = 16;

   localparam logic [3:0] S_ADD = 4'b1001;
   localparam logic [3:0] S_SUB = 4'b0110;

   localparam logic RST_C_N = 1'b1;
   localparam logic RST_EQ  = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_word_sequencer_if.sv
// rtl/alu_word_sequencer_if.sv - request/result and ALU slice signals of the word sequencer
// ALU_SEQ_OVERFLOW_EN adds the overflow flag.
interface alu_word_sequencer_if
   import alu_word_sequencer_pkg::*;
#(
   parameter int N_SLICES = 2
) ();
   localparam int W = SLICE_W * N_SLICES;

   logic               start;
   logic               ready;
   logic [W-1:0]       op_A;
   logic [W-1:0]       op_B;
   logic [3:0]         op_S;
   logic               op_M;
   logic               op_C_n;
   logic [SLICE_W-1:0] alu_A;
   logic [SLICE_W-1:0] alu_B;
   logic [3:0]         alu_S;
   logic               alu_M;
   logic               alu_C_n;
   logic [SLICE_W-1:0] alu_F;
   logic               alu_C_n_4;
   logic               alu_A_eq_B;
   logic [W-1:0]       result;
   logic               C_n_out;
   logic               A_eq_B;
   logic               zero;
   logic               done;
`ifdef ALU_SEQ_OVERFLOW_EN
   logic               overflow;
`endif

   // master: requester plus the ALU beside the sequencer; slave: the sequencer
   modport master (
      output start, op_A, op_B, op_S, op_M, op_C_n, alu_F, alu_C_n_4, alu_A_eq_B,
      input  ready, alu_A, alu_B, alu_S, alu_M, alu_C_n, result, C_n_out, A_eq_B, zero, done
`ifdef ALU_SEQ_OVERFLOW_EN
      , input overflow
`endif
   );

   modport slave (
      input  start, op_A, op_B, op_S, op_M, op_C_n, alu_F, alu_C_n_4, alu_A_eq_B,
      output ready, alu_A, alu_B, alu_S, alu_M, alu_C_n, result, C_n_out, A_eq_B, zero, done
`ifdef ALU_SEQ_OVERFLOW_EN
      , output overflow
`endif
   );

endinterface

// File: rtl/alu_word_sequencer.sv
// rtl/alu_word_sequencer.sv - streams N_SLICES 16-bit slices through one ALU, chaining carry
// ALU_SEQ_OVERFLOW_EN adds a signed overflow flag for add/subtract.
module alu_word_sequencer
   import alu_word_sequencer_pkg::*;
#(
   parameter int N_SLICES = 2
) (
   input logic                 clk,
   input logic                 rst,
   alu_word_sequencer_if.slave bus
);
   localparam int         W        = SLICE_W * N_SLICES;
   localparam logic [1:0] LAST_IDX = 2'(N_SLICES - 1);

   state_e             state_q, state_d;
   logic [1:0]         idx_q, idx_d;
   logic [W-1:0]       a_q, a_d, b_q, b_d, result_q, result_d;
   logic [3:0]         s_q, s_d;
   logic               m_q, m_d, carry_q, carry_d, eq_q, eq_d;
   logic [SLICE_W-1:0] a_slice, b_slice;

   always_comb begin
      a_slice = '0;
      b_slice = '0;
      for (int i = 0; i < N_SLICES; i++) begin
         if (idx_q == 2'(i)) begin
            a_slice = a_q[i*SLICE_W +: SLICE_W];
            b_slice = b_q[i*SLICE_W +: SLICE_W];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      s_d      = s_q;
      m_d      = m_q;
      carry_d  = carry_q;
      eq_d     = eq_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_d     = bus.op_A;
               b_d     = bus.op_B;
               s_d     = bus.op_S;
               m_d     = bus.op_M;
               carry_d = bus.op_C_n;
               eq_d    = 1'b1;
               idx_d   = 2'd0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            for (int i = 0; i < N_SLICES; i++) begin
               if (idx_q == 2'(i)) result_d[i*SLICE_W +: SLICE_W] = bus.alu_F;
            end
            carry_d = bus.alu_C_n_4;
            eq_d    = eq_q & bus.alu_A_eq_B;
            idx_d   = idx_q + 2'd1;
            if (idx_q == LAST_IDX) begin
               idx_d   = 2'd0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= 2'd0;
         a_q      <= '0;
         b_q      <= '0;
         s_q      <= 4'd0;
         m_q      <= 1'b0;
         carry_q  <= RST_C_N;
         eq_q     <= RST_EQ;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         s_q      <= s_d;
         m_q      <= m_d;
         carry_q  <= carry_d;
         eq_q     <= eq_d;
         result_q <= result_d;
      end
   end

   // outside RUN the ALU sees neutral operands and no carry-in
   assign bus.alu_A   = (state_q == ST_RUN) ? a_slice : '0;
   assign bus.alu_B   = (state_q == ST_RUN) ? b_slice : '0;
   assign bus.alu_C_n = (state_q == ST_RUN) ? carry_q : 1'b1;
   assign bus.alu_S   = s_q;
   assign bus.alu_M   = m_q;
   assign bus.ready   = (state_q == ST_IDLE);
   assign bus.done    = (state_q == ST_DONE);
   assign bus.result  = result_q;
   assign bus.C_n_out = carry_q;
   assign bus.A_eq_B  = eq_q;
   assign bus.zero    = (result_q == '0);

`ifdef ALU_SEQ_OVERFLOW_EN
   logic ovf_q, ovf_d;
   logic msb_a, msb_b, msb_f;

   assign msb_a = a_q[W-1];
   assign msb_b = b_q[W-1];
   assign msb_f = bus.alu_F[SLICE_W-1];

   always_comb begin
      ovf_d = ovf_q;
      if (state_q == ST_RUN && idx_q == LAST_IDX) begin
         ovf_d = 1'b0;
         if (!m_q && s_q == S_ADD) ovf_d = (msb_a == msb_b) && (msb_f != msb_a);
         if (!m_q && s_q == S_SUB) ovf_d = (msb_a != msb_b) && (msb_f != msb_a);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign bus.overflow = ovf_q;
`endif

endmodule
